// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and enums for the register file write arbiter
package regfile_write_arbiter_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_STATUS_REG = 30;

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_MD, SRC_EXC} src_e;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} md_state_e;

endpackage

// File: rtl/regfile_write_arbiter_hold_buffer.sv
// rtl/regfile_write_arbiter_hold_buffer.sv - one-entry valid/ready result buffer with clear
module regfile_write_arbiter_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              ready,
  output logic              full,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data
);

  assign ready = ~full;

  // Capture only while empty, so a clear and a capture never coincide.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
      rd   <= in_rd;
      data <= in_data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port among wb, md and exc
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STATUS_REG = RF_STATUS_REG,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_we,
  input  logic              wb_nop,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic              exc_valid,
  output logic              exc_ready,
  input  logic [DATA_W-1:0] exc_code,
  output logic              stall_pipe,
  output logic              md_dropped,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic              wb_eff, md_in_valid, md_cap, md_cancel, md_clear, exc_clear;
  logic              md_full, exc_full;
  logic [ADDR_W-1:0] md_buf_rd, exc_buf_rd;
  logic [DATA_W-1:0] md_buf_data, exc_buf_data;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  logic [CNT_W-1:0]  wait_cnt, wait_nxt;
  src_e              grant;
  md_state_e         md_state;

  assign wb_eff      = wb_we & ~wb_nop & (wb_rd != '0);
  // An md result aimed at r0 is handshaken but never stored.
  assign md_in_valid = md_valid & (md_rd != '0);
  assign md_cap      = md_in_valid & md_ready;

  regfile_write_arbiter_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_md_buf (
    .clock(clock), .reset(reset), .in_valid(md_in_valid), .in_rd(md_rd),
    .in_data(md_data), .clear(md_clear), .ready(md_ready), .full(md_full),
    .rd(md_buf_rd), .data(md_buf_data)
  );

  regfile_write_arbiter_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_exc_buf (
    .clock(clock), .reset(reset), .in_valid(exc_valid), .in_rd(ADDR_W'(STATUS_REG)),
    .in_data(exc_code), .clear(exc_clear), .ready(exc_ready), .full(exc_full),
    .rd(exc_buf_rd), .data(exc_buf_data)
  );

  always_comb begin
    grant  = SRC_NONE;
    g_rd   = '0;
    g_data = '0;
    if (exc_full) begin
      grant  = SRC_EXC;
      g_rd   = exc_buf_rd;
      g_data = exc_buf_data;
    end else if (md_state == FORCE || (!wb_eff && md_full)) begin
      grant  = SRC_MD;
      g_rd   = md_buf_rd;
      g_data = md_buf_data;
    end else if (wb_eff) begin
      grant  = SRC_WB;
      g_rd   = wb_rd;
      g_data = wb_data;
    end
  end

  assign stall_pipe = wb_eff & (exc_full | (md_state == FORCE));
  // A younger wb write to the buffered md destination makes the md value stale.
  assign md_cancel  = (grant == SRC_WB) & md_full & (wb_rd == md_buf_rd);
  assign md_clear   = (grant == SRC_MD) | md_cancel;
  assign exc_clear  = (grant == SRC_EXC);
  assign wait_nxt   = wait_cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_state   <= IDLE;
      wait_cnt   <= '0;
      md_dropped <= 1'b0;
    end else begin
      md_dropped <= md_cancel;
      case (md_state)
        IDLE: if (md_cap) begin
          md_state <= PEND;
          wait_cnt <= '0;
        end
        PEND: if (md_clear) begin
          md_state <= IDLE;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_nxt;
          if (wait_nxt == MAX_CNT) md_state <= FORCE;
        end
        FORCE: if (grant == SRC_MD) begin
          md_state <= IDLE;
          wait_cnt <= '0;
        end
        default: md_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= (grant != SRC_NONE);
      if (grant != SRC_NONE) begin
        ctrl_writeReg <= g_rd;
        data_writeReg <= g_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0, wb_nop = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        exc_valid = 1'b0;
  logic        exc_ready;
  logic [31:0] exc_code = '0;
  logic        stall_pipe, md_dropped, ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STATUS_REG(30), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .wb_we(wb_we), .wb_nop(wb_nop), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_code(exc_code),
    .stall_pipe(stall_pipe), .md_dropped(md_dropped),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Every register-file write seen is matched in order against the scoreboard.
  always @(negedge clock) begin
    if (reset && ctrl_writeEnable) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", ctrl_writeEnable, 1'b0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_reg", ctrl_writeReg, w.rd);
        check("wr_data", data_writeReg, w.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_we", ctrl_writeEnable, 0);
    check("rst_reg", ctrl_writeReg, 0);
    check("rst_data", data_writeReg, 0);
    check("rst_md_ready", md_ready, 1);
    check("rst_exc_ready", exc_ready, 1);
    check("rst_stall", stall_pipe, 0);
    check("rst_dropped", md_dropped, 0);
    reset = 1'b1;
    tick();

    // Plain wb write, then the same request masked as a bubble.
    wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
    push(5, 32'h1234);
    tick();
    check("wb_we", ctrl_writeEnable, 1);
    check("wb_reg", ctrl_writeReg, 5);
    wb_nop = 1;
    tick();
    check("nop_we", ctrl_writeEnable, 0);
    wb_we = 0; wb_nop = 0;
    tick();

    // Idle md: write lands two edges after the offer.
    md_valid = 1; md_rd = 7; md_data = 32'hAA;
    push(7, 32'hAA);
    tick();
    md_valid = 0;
    check("md_ready_low", md_ready, 0);
    check("md_lat1_we", ctrl_writeEnable, 0);
    tick();
    check("md_lat2_we", ctrl_writeEnable, 1);
    check("md_lat2_reg", ctrl_writeReg, 7);
    check("md_ready_back", md_ready, 1);
    tick();

    // md starvation: four wb wins, then a forced md write with wb stalled.
    md_valid = 1; md_rd = 7; md_data = 32'h77;
    tick();
    md_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wb_we = 1; wb_rd = 3; wb_data = 32'h100 + i;
      #1;
      check("starve_stall_lo", stall_pipe, 0);
      push(3, 32'h100 + i);
      tick();
    end
    wb_data = 32'h200;
    #1;
    check("starve_stall_hi", stall_pipe, 1);
    push(7, 32'h77);
    tick();
    #1;
    check("starve_after_stall", stall_pipe, 0);
    check("starve_md_ready", md_ready, 1);
    push(3, 32'h200);
    tick();
    wb_we = 0;
    tick();

    // Ordering: younger wb to the buffered md destination cancels md.
    wb_we = 0;
    md_valid = 1; md_rd = 9; md_data = 32'h99;
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    push(4, 32'h44);
    tick();
    md_valid = 0;
    wb_rd = 9; wb_data = 32'h55;
    push(9, 32'h55);
    tick();
    wb_we = 0;
    check("order_dropped", md_dropped, 1);
    check("order_md_ready", md_ready, 1);
    tick();
    check("order_dropped_pulse", md_dropped, 0);
    tick();

    // Exception vs wb to the status register.
    exc_valid = 1; exc_code = 32'h3;
    tick();
    exc_valid = 0;
    check("exc_ready_low", exc_ready, 0);
    wb_we = 1; wb_rd = 30; wb_data = 32'hABCD;
    #1;
    check("exc_stall", stall_pipe, 1);
    push(30, 32'h3);
    tick();
    #1;
    check("exc_stall_clr", stall_pipe, 0);
    check("exc_ready_back", exc_ready, 1);
    push(30, 32'hABCD);
    tick();
    wb_we = 0;
    tick();

    // md aimed at r0 is accepted and discarded.
    md_valid = 1; md_rd = 0; md_data = 32'hDEAD;
    tick();
    md_valid = 0;
    check("r0_md_ready", md_ready, 1);
    tick();
    tick();
    check("r0_dropped", md_dropped, 0);

    // Asynchronous reset with md buffered discards it.
    wb_we = 1; wb_rd = 4; wb_data = 32'h44;
    md_valid = 1; md_rd = 12; md_data = 32'hC;
    tick();
    wb_we = 0; md_valid = 0;
    check("pre_rst_we", ctrl_writeEnable, 1);
    check("pre_rst_md_ready", md_ready, 0);
    #1 reset = 0;
    #1;
    check("async_rst_we", ctrl_writeEnable, 0);
    check("async_rst_reg", ctrl_writeReg, 0);
    check("async_rst_data", data_writeReg, 0);
    check("async_rst_md_ready", md_ready, 1);
    tick();
    reset = 1;
    tick();
    tick();
    tick();
    check("post_rst_we", ctrl_writeEnable, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
